mealy_decoder: RTL
==================

MEALY_DECODER -- requirements
Module: mealy_decoder

Interface
REQ-001 The block SHALL use reset reset, asynchronous, active-high; clock clk.
REQ-002 The port list SHALL be, one per line, name direction width meaning:
  clk         in   1   rising-edge clock
  reset       in   1   asynchronous active-high reset
  code_in     in   1   encoded bit from the 3-state Mealy encoder
  code_valid  in   1   code_in is valid this cycle
  sync_clr    in   1   synchronous clear of the decode state and word assembly
  word_ack    in   1   consumer accepts word_out
  bit_out     out  1   recovered plaintext bit
  bit_valid   out  1   bit_out valid, one-cycle pulse
  word_out    out  16  assembled 16-bit plaintext word
  word_valid  out  1   word_out pending; held until acknowledged
  overrun     out  1   sticky flag: a word completed while word_valid was still high
  state_out   out  2   current decoder state, mirrors the encoder state

Function
REQ-003 Decoder states SHALL be S0=2'b00, S1=2'b01 and S2=2'b10; the encoding 2'b11 is illegal.
REQ-004 On a cycle with code_valid=1, the state, decoded bit and next state SHALL follow this table:
  S0: code 0 -> bit 1, next S1; code 1 -> bit 0, next S2
  S1: code 1 -> bit 1, next S0; code 0 -> bit 0, next S2
  S2: code 0 -> bit 1, next S1; code 1 -> bit 0, next S0
REQ-005 In the illegal state, any code_valid SHALL produce bit 0 and next state S0.
REQ-006 With code_valid=0 the state SHALL hold and bit_valid SHALL be 0.
REQ-007 bit_out and bit_valid SHALL be registered: one cycle of latency from the code_valid edge.
REQ-008 Each decoded bit SHALL shift into a 16-bit register from the LSB end (shift left), so the first bit of a word ends at bit 15.
REQ-009 A 4-bit counter SHALL count decoded bits; on the 16th bit (count 15) the block SHALL:
  - load word_out with the complete word, including the 16th bit;
  - set word_valid;
  - wrap the count to 0.
REQ-010 word_valid SHALL clear on the cycle after word_ack=1; word_ack while word_valid=0 SHALL be ignored.
REQ-011 When a word completes and word_valid is 1 without a same-cycle word_ack:
  - word_out SHALL be overwritten with the new word;
  - word_valid SHALL stay 1;
  - overrun SHALL set and stay set.
REQ-012 When a word completes in the same cycle as word_ack, the new word SHALL load, word_valid SHALL stay 1, and overrun SHALL NOT set.
REQ-013 sync_clr=1 SHALL force the following, taking priority over a simultaneous code_valid:
  - state S0, counter 0, shift register 0;
  - bit_valid 0, word_valid 0, overrun 0.
REQ-014 state_out SHALL equal the registered state at all times.

Reset
REQ-015 Reset SHALL asynchronously force the following, taking priority over all other inputs:
  - state S0, counter 0, shift register 0;
  - bit_out 0, bit_valid 0, word_out 16'h0000, word_valid 0, overrun 0.
REQ-016 Reset asserted mid-word SHALL discard the partial word; the first bit after release SHALL begin a new word.

Structure
REQ-017 A shared package SHALL hold:
  - state constants S0, S1 and S2;
  - WORD_W=16;
  - CNT_W=4.
REQ-018 The block SHALL use one sub-module, mealy_decode_step: a combinational (state, code) -> (bit, next_state) table, reusable by the bench as a reference model.

Verification
REQ-019 Reset check: assert reset mid-operation -> all outputs 0 and state_out=2'b00 immediately, before any clock edge.
REQ-020 Single step: from S0, code 0 valid -> next cycle bit_out=1, bit_valid=1, state_out=2'b01.
REQ-021 Full word: codes 1000_0010_0010_0100 (left first, all valid) -> word_out=16'h5772, word_valid=1, state_out=2'b10.
REQ-022 Overrun: two back-to-back words with no word_ack -> word_out holds the second word, overrun=1; a word completing in the same cycle as word_ack -> overrun=0.
REQ-023 Clear priority: sync_clr=1 together with code_valid=1 after 7 bits -> state_out=00 and count 0; the next 16 codes yield a fresh correct word.
REQ-024 Stall: code_valid low for 5 cycles mid-word -> state and count hold, and the word completes correctly.

Source files
------------

// File: rtl/mealy_decoder_pkg.sv
// Shared definitions for the Mealy decoder slice.
//   state_t  : decoder state encoding (S0/S1/S2; 2'b11 is illegal)
//   WORD_W   : width of the assembled plaintext word
//   CNT_W    : width of the decoded-bit counter
//   CNT_LAST : counter value at which a word completes
package mealy_decoder_pkg;

  localparam int WORD_W = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    S0    = 2'b00,
    S1    = 2'b01,
    S2    = 2'b10,
    S_ILL = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

endpackage

// File: rtl/mealy_decode_step.sv
// Combinational single-step table of the 3-state Mealy code.
// Ports:
//   state      in  current decoder state
//   code       in  received encoded bit
//   bit_val    out recovered plaintext bit for this transition
//   next_state out state after consuming code
module mealy_decode_step
  import mealy_decoder_pkg::*;
(
  input  state_t state,
  input  logic   code,
  output logic   bit_val,
  output state_t next_state
);

  always_comb begin
    bit_val    = 1'b0;
    next_state = S0;
    case (state)
      S0: begin
        if (!code) begin
          bit_val    = 1'b1;
          next_state = S1;
        end else begin
          bit_val    = 1'b0;
          next_state = S2;
        end
      end
      S1: begin
        if (code) begin
          bit_val    = 1'b1;
          next_state = S0;
        end else begin
          bit_val    = 1'b0;
          next_state = S2;
        end
      end
      S2: begin
        if (!code) begin
          bit_val    = 1'b1;
          next_state = S1;
        end else begin
          bit_val    = 1'b0;
          next_state = S0;
        end
      end
      // Illegal encoding recovers to S0 and yields a 0 bit.
      default: begin
        bit_val    = 1'b0;
        next_state = S0;
      end
    endcase
  end

endmodule

// File: rtl/mealy_decoder.sv
// Mealy decoder: recovers plaintext bits from a 3-state Mealy-encoded
// stream and assembles them MSB-first into 16-bit words.
// Ports:
//   clk, reset  rising-edge clock, asynchronous active-high reset
//   code_in     encoded bit, qualified by code_valid
//   sync_clr    synchronous clear of decode state and word assembly
//   word_ack    consumer accepts the pending word
//   bit_out     registered decoded bit, qualified by bit_valid (1-cycle pulse)
//   word_out    last completed word
//   word_valid  a word is pending; held until acknowledged
//   overrun     sticky: a word completed while the previous one was pending
//   state_out   current decoder state
module mealy_decoder
  import mealy_decoder_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              code_in,
  input  logic              code_valid,
  input  logic              sync_clr,
  input  logic              word_ack,
  output logic              bit_out,
  output logic              bit_valid,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  output logic              overrun,
  output logic [1:0]        state_out
);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [WORD_W-1:0]  shift_reg, shift_next;
  logic [WORD_W-1:0]  word_reg, word_next;
  logic               bit_out_reg, bit_out_next;
  logic               bit_valid_reg, bit_valid_next;
  logic               word_valid_reg, word_valid_next;
  logic               overrun_reg, overrun_next;

  logic               step_bit;
  state_t             step_state;
  logic [WORD_W-1:0]  shift_shifted;
  logic               word_done;

  mealy_decode_step u_step (
    .state      (state_reg),
    .code       (code_in),
    .bit_val    (step_bit),
    .next_state (step_state)
  );

  // Shift-left with the new bit entering at the LSB, so the first bit of a
  // word ends up at bit 15 after sixteen shifts.
  assign shift_shifted[0] = step_bit;
  generate
    for (genvar gi = 1; gi < WORD_W; gi++) begin : g_shift
      assign shift_shifted[gi] = shift_reg[gi-1];
    end
  endgenerate

  // The 16th bit is taken from the shifter input path so it lands in
  // word_out on the same edge it is decoded.
  assign word_done = code_valid && !sync_clr && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= S0;
      cnt_reg        <= '0;
      shift_reg      <= '0;
      word_reg       <= '0;
      bit_out_reg    <= 1'b0;
      bit_valid_reg  <= 1'b0;
      word_valid_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      shift_reg      <= shift_next;
      word_reg       <= word_next;
      bit_out_reg    <= bit_out_next;
      bit_valid_reg  <= bit_valid_next;
      word_valid_reg <= word_valid_next;
      overrun_reg    <= overrun_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    shift_next      = shift_reg;
    word_next       = word_reg;
    bit_out_next    = bit_out_reg;
    bit_valid_next  = 1'b0;
    word_valid_next = word_valid_reg;
    overrun_next    = overrun_reg;

    if (sync_clr) begin
      // Clear wins over a simultaneous code; word_out and bit_out keep
      // their last values but are no longer flagged valid.
      state_next      = S0;
      cnt_next        = '0;
      shift_next      = '0;
      word_valid_next = 1'b0;
      overrun_next    = 1'b0;
    end else begin
      if (code_valid) begin
        state_next     = step_state;
        shift_next     = shift_shifted;
        bit_out_next   = step_bit;
        bit_valid_next = 1'b1;
        // 4-bit counter wraps 15 -> 0 naturally at word completion.
        cnt_next       = cnt_reg + CNT_W'(1);
      end

      if (word_done) begin
        word_next       = shift_shifted;
        word_valid_next = 1'b1;
        // A same-cycle ack consumes the old word, so it is not an overrun.
        if (word_valid_reg && !word_ack) begin
          overrun_next = 1'b1;
        end
      end else if (word_ack && word_valid_reg) begin
        word_valid_next = 1'b0;
      end
    end
  end

  assign bit_out    = bit_out_reg;
  assign bit_valid  = bit_valid_reg;
  assign word_out   = word_reg;
  assign word_valid = word_valid_reg;
  assign overrun    = overrun_reg;
  assign state_out  = state_reg;

endmodule
